// File: rtl/avmm_traffic_initiator.sv
// Avalon-MM traffic initiator: writes a seeded pattern to NUM_LINES lines, reads them back
// in order and reports mismatches, worst read latency and a response timeout.
package avmm_memory_pkg;
    localparam int DATA_WIDTH          = 512;
    localparam int DATA_WIDTH_IN_BYTES = DATA_WIDTH / 8;
endpackage

// state   | meaning
// S_IDLE  | quiet, waiting for start
// S_WRITE | one pattern write per ready cycle
// S_READ  | reads issued while below the outstanding limit
// S_WAIT  | draining the remaining read responses
// S_DONE  | results held, start restarts the run
module avmm_traffic_initiator
    import avmm_memory_pkg::*;
#(
    parameter logic [45:0] BASE_ADDR       = '0,
    parameter int          NUM_LINES       = 16,
    parameter int          MAX_OUTSTANDING = 8,
    parameter int          TIMEOUT         = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [31:0]                    seed,
    output logic                           read,
    output logic                           write,
    output logic [51:6]                    address,
    output logic [DATA_WIDTH_IN_BYTES-1:0] byteenable,
    output logic [DATA_WIDTH-1:0]          writedata,
    input  logic [DATA_WIDTH-1:0]          readdata,
    input  logic                           readdatavalid,
    input  logic                           ready,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [15:0]                    error_count,
    output logic [51:6]                    first_err_addr,
    output logic [15:0]                    max_latency,
    output logic                           timeout_err
);
    localparam int WORDS  = DATA_WIDTH / 32;
    localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int LAST_I = (NUM_LINES > 0) ? NUM_LINES - 1 : 0;
    localparam logic [15:0]   LAST_IDX = 16'(LAST_I);
    localparam logic [OW-1:0] MAX_OS   = OW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     seed_q, seed_d;
    logic [15:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rsp_idx_q, rsp_idx_d;
    logic [OW-1:0]   os_q, os_d;
    logic [15:0]     err_q, err_d, maxlat_q, maxlat_d;
    logic [45:0]     first_q, first_d;
    logic            mis_seen_q, mis_seen_d, to_err_q, to_err_d;
    logic [31:0]     to_cnt_q, to_cnt_d, cyc_q;
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [31:0]     ts_mem [MAX_OUTSTANDING];

    logic            active, rd_phase, to_fire, rsp_ok, spurious, mismatch;
    logic [31:0]     lat_raw;
    logic [15:0]     lat_sat;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] s, input logic [15:0] idx);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < WORDS; k++) p[k*32 +: 32] = s ^ {idx, 16'(k)};
        return p;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign active   = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_WAIT);
    assign rd_phase = (state_q == S_READ) || (state_q == S_WAIT);
    assign to_fire  = rd_phase && (os_q != '0) && !readdatavalid && (to_cnt_q == TO_LAST);
    assign rsp_ok   = active && readdatavalid && (os_q != '0);
    assign spurious = active && readdatavalid && (os_q == '0);
    assign mismatch = rsp_ok && (readdata != pattern(seed_q, rsp_idx_q));
    assign lat_raw  = cyc_q - ts_mem[rp_q];
    assign lat_sat  = (|lat_raw[31:16]) ? 16'hFFFF : lat_raw[15:0];

    // Requests are combinationally gated by ready so each asserted cycle is one accepted request.
    assign write      = (state_q == S_WRITE) && ready;
    assign read       = (state_q == S_READ) && ready && (os_q < MAX_OS) && !to_fire;
    assign address    = write ? BASE_ADDR + {30'd0, wr_idx_q} :
                        read  ? BASE_ADDR + {30'd0, rd_idx_q} : '0;
    assign byteenable = (read || write) ? '1 : '0;
    assign writedata  = write ? pattern(seed_q, wr_idx_q) : '0;

    assign busy           = active;
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == '0) && !to_err_q;
    assign error_count    = err_q;
    assign first_err_addr = first_q;
    assign max_latency    = maxlat_q;
    assign timeout_err    = to_err_q;

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        rsp_idx_d  = rsp_idx_q;
        os_d       = os_q;
        err_d      = err_q;
        first_d    = first_q;
        mis_seen_d = mis_seen_q;
        maxlat_d   = maxlat_q;
        to_err_d   = to_err_q;
        to_cnt_d   = to_cnt_q;
        wp_d       = wp_q;
        rp_d       = rp_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = (NUM_LINES == 0) ? S_DONE : S_WRITE;
                    seed_d     = seed;
                    wr_idx_d   = '0;
                    rd_idx_d   = '0;
                    rsp_idx_d  = '0;
                    os_d       = '0;
                    err_d      = '0;
                    first_d    = '0;
                    mis_seen_d = 1'b0;
                    maxlat_d   = '0;
                    to_err_d   = 1'b0;
                    to_cnt_d   = '0;
                    wp_d       = '0;
                    rp_d       = '0;
                end
            end
            S_WRITE: begin
                if (write) begin
                    wr_idx_d = wr_idx_q + 16'd1;
                    if (wr_idx_q == LAST_IDX) state_d = S_READ;
                end
            end
            S_READ: begin
                if (read) begin
                    rd_idx_d = rd_idx_q + 16'd1;
                    if (rd_idx_q == LAST_IDX) state_d = S_WAIT;
                end
            end
            default: ;
        endcase

        if (active) begin
            if (read) wp_d = ptr_next(wp_q);
            if (rsp_ok) begin
                rp_d      = ptr_next(rp_q);
                rsp_idx_d = rsp_idx_q + 16'd1;
                if (lat_sat > maxlat_q) maxlat_d = lat_sat;
                if (mismatch && !mis_seen_q) begin
                    mis_seen_d = 1'b1;
                    first_d    = BASE_ADDR + {30'd0, rsp_idx_q};
                end
            end
            if ((spurious || mismatch) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
            if (read && !rsp_ok)      os_d = os_q + OW'(1);
            else if (!read && rsp_ok) os_d = os_q - OW'(1);
            to_cnt_d = (rd_phase && (os_q != '0) && !readdatavalid) ? to_cnt_q + 32'd1 : '0;
            if ((state_q == S_WAIT) && (os_d == '0)) state_d = S_DONE;
            if (to_fire) begin
                to_err_d = 1'b1;
                state_d  = S_DONE;
                os_d     = '0;
                wp_d     = '0;
                rp_d     = '0;
                to_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            rsp_idx_q  <= '0;
            os_q       <= '0;
            err_q      <= '0;
            first_q    <= '0;
            mis_seen_q <= 1'b0;
            maxlat_q   <= '0;
            to_err_q   <= 1'b0;
            to_cnt_q   <= '0;
            cyc_q      <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            rsp_idx_q  <= rsp_idx_d;
            os_q       <= os_d;
            err_q      <= err_d;
            first_q    <= first_d;
            mis_seen_q <= mis_seen_d;
            maxlat_q   <= maxlat_d;
            to_err_q   <= to_err_d;
            to_cnt_q   <= to_cnt_d;
            cyc_q      <= cyc_q + 32'd1;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
        end
    end

    // Issue timestamps need no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (read) ts_mem[wp_q] <= cyc_q;
    end
endmodule

// File: tb/tb_avmm_traffic_initiator.sv
// Bench for avmm_traffic_initiator: in-order latency memory model plus request/response scoreboard.
module tb_avmm_traffic_initiator;
    import avmm_memory_pkg::*;

    localparam int DW   = DATA_WIDTH;
    localparam int BW   = DATA_WIDTH_IN_BYTES;
    localparam int NL   = 16;
    localparam int MAXO = 8;
    localparam int TMO  = 1024;
    localparam logic [45:0]   BASE = 46'h3FFF_FFFF_FFFA;
    localparam logic [DW-1:0] JUNK = {(DW/32){32'hDEAD_BEEF}};

    logic clk, rstn, start, start0, ready, rdv;
    logic [31:0] seed;
    logic [DW-1:0] readdata;

    logic read, write, busy, done, pass, timeout_err;
    logic [51:6] address, first_err_addr;
    logic [BW-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [15:0] error_count, max_latency;

    logic read0, write0, busy0, done0, pass0, to0;
    logic [51:6] address0, fea0;
    logic [BW-1:0] be0;
    logic [DW-1:0] wd0;
    logic [15:0] err0, ml0;

    avmm_traffic_initiator #(.BASE_ADDR(BASE), .NUM_LINES(NL), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .seed(seed),
        .read(read), .write(write), .address(address), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata), .readdatavalid(rdv), .ready(ready),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_err_addr(first_err_addr), .max_latency(max_latency), .timeout_err(timeout_err));

    avmm_traffic_initiator #(.BASE_ADDR(BASE), .NUM_LINES(0), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .seed(seed),
        .read(read0), .write(write0), .address(address0), .byteenable(be0),
        .writedata(wd0), .readdata(readdata), .readdatavalid(rdv), .ready(ready),
        .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
        .first_err_addr(fea0), .max_latency(ml0), .timeout_err(to0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned issue;
        logic [45:0] addr;
        int          idx;
    } req_t;

    req_t pend[$];
    logic [DW-1:0] mem [logic [45:0]];

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0, lat_cfg = 1, last_rsp_cyc = 0, exp_max = 0, os_pre = 0;
    int wr_cnt, rd_cnt, rsp_cnt, exp_err, corrupt_line;
    bit gate_mode, inj_spur, mis_seen;
    logic [31:0] seed_m;
    logic [45:0] exp_first;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] s, input int i);
        logic [DW-1:0] p;
        logic [15:0] ii, kk;
        ii = i[15:0];
        for (int k = 0; k < DW / 32; k++) begin
            kk = k[15:0];
            p[k*32 +: 32] = s ^ {ii, kk};
        end
        return p;
    endfunction

    // One clock: drive memory inputs just after the edge, score the DUT at the falling edge.
    task automatic step();
        req_t r;
        logic [DW-1:0] d;
        logic [45:0] a;
        int unsigned l;
        @(posedge clk);
        #1;
        cyc++;
        os_pre   = pend.size();
        rdv      = 1'b0;
        readdata = JUNK;
        if (pend.size() > 0 && (cyc - pend[0].issue) >= lat_cfg) begin
            r = pend.pop_front();
            d = mem.exists(r.addr) ? mem[r.addr] : '0;
            if (r.idx == corrupt_line) begin
                d[0] = ~d[0];
                exp_err++;
                if (!mis_seen) begin
                    mis_seen  = 1'b1;
                    exp_first = r.addr;
                end
            end
            rdv      = 1'b1;
            readdata = d;
            l = cyc - r.issue;
            if (l > 65535) l = 65535;
            if (l > exp_max) exp_max = l;
            rsp_cnt++;
            last_rsp_cyc = cyc;
        end else if (inj_spur) begin
            rdv = 1'b1;
            if (busy) exp_err++;
        end
        inj_spur = 1'b0;
        ready = (gate_mode && (cyc[0] || pend.size() >= 57)) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("rw_exclusive", 64'(read && write), 64'd0);
        chk("byteenable", 64'(byteenable), (read || write) ? 64'({BW{1'b1}}) : 64'd0);
        chk("zero_lines_quiet", 64'(read0 || write0), 64'd0);
        if (write) begin
            chk("write_ready", 64'(ready), 64'd1);
            chk("write_addr", 64'(address), 64'(46'(BASE + 46'(wr_cnt))));
            chkw("write_data", writedata, pat(seed_m, wr_cnt));
            a = address;
            mem[a] = writedata;
            wr_cnt++;
        end
        if (read) begin
            chk("read_ready", 64'(ready), 64'd1);
            chk("read_addr", 64'(address), 64'(46'(BASE + 46'(rd_cnt))));
            chk("outstanding_limit", 64'(os_pre < MAXO), 64'd1);
            a = address;
            r = '{issue: cyc, addr: a, idx: rd_cnt};
            pend.push_back(r);
            rd_cnt++;
        end
    endtask

    task automatic run_start(input logic [31:0] s, input int unsigned lat, input bit gate, input int corrupt);
        pend.delete();
        wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; exp_err = 0; exp_max = 0;
        mis_seen = 1'b0; exp_first = '0;
        seed = s; seed_m = s; lat_cfg = lat; gate_mode = gate; corrupt_line = corrupt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic final_checks();
        chk("error_count", 64'(error_count), 64'(exp_err));
        chk("pass", 64'(pass), 64'(exp_err == 0));
        chk("max_latency", 64'(max_latency), 64'(exp_max));
        chk("first_err_addr", 64'(first_err_addr), 64'(exp_first));
        chk("timeout_err", 64'(timeout_err), 64'd0);
        chk("write_count", 64'(wr_cnt), 64'(NL));
        chk("read_count", 64'(rd_cnt), 64'(NL));
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("done_after_last_rsp", 64'(cyc), 64'(last_rsp_cyc + 1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, 64'({read, write, busy, done, pass, timeout_err, |address, |byteenable,
                                 |writedata, |error_count, |first_err_addr, |max_latency}), 64'd0);
        chk({tag, "_outs0"}, 64'({read0, write0, busy0, done0, pass0, to0, |address0, |be0,
                                  |wd0, |err0, |fea0, |ml0}), 64'd0);
    endtask

    initial begin
        int n;
        int unsigned first_rd, dt;
        bit seen_rd;
        rstn = 1'b0; start = 1'b0; start0 = 1'b0; seed = '0; ready = 1'b1;
        rdv = 1'b0; readdata = '0; inj_spur = 1'b0; gate_mode = 1'b0; corrupt_line = -1;
        wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; exp_err = 0; mis_seen = 1'b0; exp_first = '0;
        seed_m = '0;
        #3;
        chk_all_zero("reset");
        step();
        step();
        rstn = 1'b1;
        step();

        // Basic run, latency 100
        run_start(32'hA5A5_0000, 100, 1'b0, -1);
        chk("first_write_next_cycle", 64'(wr_cnt), 64'd1);
        wait_done(3000);
        final_checks();
        chk("basic_pass_lit", 64'(pass), 64'd1);
        chk("basic_maxlat_lit", 64'(max_latency), 64'd100);
        chk("basic_err_lit", 64'(error_count), 64'd0);
        // Stray response in DONE changes nothing
        inj_spur = 1'b1;
        step();
        chk("done_spurious_ignored", 64'(error_count), 64'd0);
        chk("done_spurious_pass", 64'(pass), 64'd1);

        // Ready gating
        run_start(32'h0F0F_1234, 5, 1'b1, -1);
        wait_done(3000);
        final_checks();
        chk("gated_pass_lit", 64'(pass), 64'd1);

        // Corrupted line 3
        run_start(32'h1357_9BDF, 7, 1'b0, 3);
        wait_done(3000);
        final_checks();
        chk("corrupt_err_lit", 64'(error_count), 64'd1);
        chk("corrupt_addr_lit", 64'(first_err_addr), 64'(46'h3FFF_FFFF_FFFD));
        chk("corrupt_pass_lit", 64'(pass), 64'd0);

        // Spurious response during WRITE
        run_start(32'h2468_ACE0, 6, 1'b0, -1);
        step();
        inj_spur = 1'b1;
        step();
        wait_done(3000);
        final_checks();
        chk("spurious_err_lit", 64'(error_count), 64'd1);

        // Outstanding limit and timeout
        run_start(32'hCAFE_F00D, 2000, 1'b0, -1);
        n = 0; seen_rd = 1'b0; first_rd = 0;
        while (!done && n < 3000) begin
            step();
            n++;
            if (!seen_rd && rd_cnt > 0) begin
                seen_rd  = 1'b1;
                first_rd = cyc;
            end
        end
        chk("timeout_done", 64'(done), 64'd1);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        chk("timeout_pass", 64'(pass), 64'd0);
        chk("timeout_reads", 64'(rd_cnt), 64'(MAXO));
        chk("timeout_maxlat", 64'(max_latency), 64'd0);
        dt = cyc - first_rd;
        chk("timeout_window", 64'(dt >= TMO && dt <= TMO + 8), 64'd1);

        // Reset during READ
        run_start(32'h1234_5678, 20, 1'b0, -1);
        n = 0;
        while (rd_cnt < 3 && n < 200) begin
            step();
            n++;
        end
        chk("reached_read", 64'(rd_cnt >= 3), 64'd1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        pend.delete();
        step();
        step();
        rstn = 1'b1;
        step();
        run_start(32'h8765_4321, 9, 1'b0, -1);
        wait_done(3000);
        final_checks();
        chk("after_reset_pass_lit", 64'(pass), 64'd1);

        // Zero lines
        chk("zero_idle_done", 64'(done0), 64'd0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("zero_done", 64'(done0), 64'd1);
        chk("zero_pass", 64'(pass0), 64'd1);
        step();
        step();
        chk("zero_still_done", 64'(done0 && !busy0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/avmm_traffic_initiator.md
# avmm_traffic_initiator

- Avalon-MM initiator that drives the line-addressed memory interface from the requesting side.
- On `start` it writes a seeded pattern to `NUM_LINES` consecutive 64-byte lines, reads them back, compares in order, and reports pass/fail, mismatch count and worst observed read latency.
- It is the self-checking traffic source for the AVMM memory sim model and connects port-for-port to one channel of it.
- Widths `DATA_WIDTH` and `DATA_WIDTH_IN_BYTES` come from `avmm_memory_pkg`; `DATA_WIDTH` is a multiple of 32.

## Interface

**Parameters**

- `BASE_ADDR`, default 0: first line address, 46 bits, in units of 64 B.
- `NUM_LINES`, default 16: number of lines written and then read, range 0..65535.
- `MAX_OUTSTANDING`, default 8: maximum number of in-flight reads, range 1..32.
- `TIMEOUT`, default 1024: limit on consecutive cycles with reads outstanding and no `readdatavalid`.

**Ports** (reset is asynchronous and active-low)

- `clk` in 1: single clock; all state changes on its rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a run. Honoured in IDLE or DONE only.
- `seed` in 32: pattern seed, sampled on the accepted `start`.
- `read` out 1: read request.
- `write` out 1: write request.
- `address` out [51:6]: line address of the request.
- `byteenable` out `DATA_WIDTH_IN_BYTES`: always all ones when `read` or `write` is high, 0 otherwise.
- `writedata` out `DATA_WIDTH`: write payload.
- `readdata` in `DATA_WIDTH`: read response data.
- `readdatavalid` in 1: read response strobe, one per read, responses returned in request order.
- `ready` in 1: responder can accept a request in this cycle.
- `busy` out 1: high in WRITE, READ and WAIT.
- `done` out 1: high in DONE.
- `pass` out 1: in DONE, equals `error_count==0 && !timeout_err`; 0 in all other states.
- `error_count` out 16: mismatches plus spurious responses, saturating at 0xFFFF.
- `first_err_addr` out [51:6]: line address of the first mismatch.
- `max_latency` out 16: largest issue-to-response distance, saturating.
- `timeout_err` out 1: set when the timeout fires.

## Operation

- **Pattern.** 32-bit word k of line i = `seed ^ {i[15:0], k[15:0]}`, with word 0 in the LSBs.
- **Transfer rule.** `read` or `write` is asserted only in a cycle where `ready`=1, gated combinationally by `ready`.
  - Every cycle with `read` or `write` high is exactly one accepted request.
  - Requests are never held across a `ready`=0 cycle.
  - `read` and `write` are never high together.
- **IDLE.** Outputs quiet. An accepted `start` clears `error_count`, `first_err_addr`, `max_latency`, `timeout_err` and the index counters.
  - Next state is WRITE, or DONE directly if `NUM_LINES`=0.
- **WRITE.** Issues a write to `BASE_ADDR+wr_idx` for each `wr_idx` from 0 to `NUM_LINES-1`, one per `ready` cycle.
  - After the last write is accepted, next state is READ.
  - No wait is needed: the responder is in-order, so write-before-read ordering is guaranteed.
- **READ.** Issues a read to `BASE_ADDR+rd_idx` when `ready`=1 and `outstanding < MAX_OUTSTANDING`.
  - After the last read is accepted, next state is WAIT.
- **WAIT.** Collects the remaining responses. When `outstanding`=0, next state is DONE.
- **DONE.** `done`=1. A new `start` restarts the run exactly as from IDLE.
- **Outstanding counter.** +1 on an accepted read, −1 on `readdatavalid`; a simultaneous accept and response leaves it unchanged.
- **Response check.** Expected data uses the `rsp_idx` counter.
  - On a mismatch: increment `error_count`, and load `first_err_addr`=`BASE_ADDR+rsp_idx` if this is the first error of the run.
- **Latency tracking.** A timestamp FIFO of depth `MAX_OUTSTANDING` stores a free-running 32-bit cycle count at each read issue.
  - On response: latency = count − popped timestamp, modulo 2^32, saturated to 16 bits. `max_latency` is updated when the new latency is larger.
- **Spurious response.** `readdatavalid` with `outstanding`=0 in WRITE, READ or WAIT increments `error_count` and the data is ignored.
  - In IDLE or DONE a spurious response is ignored and nothing changes.
- **Timeout.** In READ or WAIT, a counter runs while `outstanding`>0 and is cleared on each `readdatavalid`.
  - At `TIMEOUT` cycles: set `timeout_err`, go to DONE, and drop the outstanding count and timestamp FIFO to 0.

## Timing

- **Reset.** On `rstn` low, every output goes to 0 immediately (asynchronous) and state goes to IDLE. This applies mid-run as well; no partial results are retained.
- **Start latency.** `start` is accepted at edge N, giving WRITE from cycle N+1. The first `write` can appear in cycle N+1 if `ready`=1.
- **Write phase.** Takes exactly `NUM_LINES` `ready`-high cycles. The READ state starts in the cycle after the last write acceptance.
- **Response processing.** `readdatavalid` in cycle M: the check and counter updates are visible at M+1. After the final response in M, `done` and `pass` are valid from cycle M+1.
- **Latency definition.** Latency is measured from the issue cycle to the response cycle. Against a memory with latency L, the result is L.
- **Wrap-around.** The address wraps modulo 2^46. Index counters are 16-bit and never exceed `NUM_LINES`.

## Test plan

1. **Basic run.** Memory model with LATENCY=100, `NUM_LINES`=16, `seed`=0xA5A50000, `start` pulse → 16 writes then 16 reads, `done`=1, `pass`=1, `error_count`=0, `max_latency`=100.
2. **Ready gating.** Memory model `ready` low on odd cycles and whenever its FIFO holds ≥57 entries → exactly 16 write pulses and 16 read pulses, none coinciding with `ready`=0, `pass`=1.
3. **Data corruption.** Bench flips bit 0 of the line-3 `readdata` → `error_count`=1, `first_err_addr`=`BASE_ADDR`+3, `pass`=0.
4. **Outstanding limit and timeout.** LATENCY=2000, `TIMEOUT`=1024 → read issue stops at 8 outstanding, `timeout_err`=1 about 1024 cycles later, `done`=1, `pass`=0.
5. **Reset mid-run.** Assert `rstn` low during READ → all outputs 0 in the same cycle. A fresh `start` after release gives `pass`=1.
6. **Zero lines.** `NUM_LINES`=0 → `done`=1 one cycle after `start`, no `read`/`write` pulses, `pass`=1.
